// File: rtl/io_port_bridge.sv
// Host <-> CPU I/O port bridge: two DEPTH x 64 circular FIFOs with edge-triggered CPU access.
// Define IO_PORT_BRIDGE_STATS_EN to add the in_words/out_words accepted-word counters.
module io_port_bridge #(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       cpu_in_signal,
   output logic [63:0]                cpu_in_data,
   input  logic                       cpu_out_signal,
   input  logic [63:0]                cpu_out_data,
   input  logic                       host_tx_valid,
   input  logic [63:0]                host_tx_data,
   output logic                       host_tx_ready,
   output logic                       host_rx_valid,
   output logic [63:0]                host_rx_data,
   input  logic                       host_rx_ready,
   input  logic                       clear_flags,
   output logic                       in_underflow,
   output logic                       out_overflow,
`ifdef IO_PORT_BRIDGE_STATS_EN
   output logic [31:0]                in_words,
   output logic [31:0]                out_words,
`endif
   output logic [$clog2(DEPTH):0]     in_count,
   output logic [$clog2(DEPTH):0]     out_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [63:0]   r_in_mem  [DEPTH];
   logic [63:0]   r_out_mem [DEPTH];
   logic [AW-1:0] r_in_wp, r_in_rp, r_out_wp, r_out_rp;
   logic [CW-1:0] r_in_cnt, r_out_cnt;
   logic          r_in_sig_d, r_out_sig_d;
   logic          r_arm;
   logic          r_unf, r_ovf;

   logic w_rd_ev, w_wr_ev;
   logic w_in_empty, w_out_full;
   logic w_in_push, w_in_pop;
   logic w_out_push, w_out_pop;
   logic w_unf_set, w_ovf_set;

   // Events are suppressed for the first cycle after reset so a level
   // already high at release is only sampled, never counted.
   assign w_rd_ev    = r_arm & cpu_in_signal & ~r_in_sig_d;
   assign w_wr_ev    = r_arm & cpu_out_signal & ~r_out_sig_d;

   assign w_in_empty = (r_in_cnt == '0);
   assign w_out_full = (r_out_cnt == FULL);

   assign host_tx_ready = (r_in_cnt != FULL);
   assign w_in_push     = host_tx_valid & host_tx_ready;
   assign w_in_pop      = w_rd_ev & ~w_in_empty;
   assign w_unf_set     = w_rd_ev & w_in_empty;

   assign host_rx_valid = (r_out_cnt != '0);
   assign w_out_pop     = host_rx_valid & host_rx_ready;
   assign w_out_push    = w_wr_ev & (~w_out_full | w_out_pop);
   assign w_ovf_set     = w_wr_ev & w_out_full & ~w_out_pop;

   assign cpu_in_data   = w_in_empty ? 64'h0 : r_in_mem[r_in_rp];
   assign host_rx_data  = r_out_mem[r_out_rp];
   assign in_count      = r_in_cnt;
   assign out_count     = r_out_cnt;
   assign in_underflow  = r_unf;
   assign out_overflow  = r_ovf;

   always_ff @(posedge clk) begin
      if (w_in_push)  r_in_mem[r_in_wp]   <= host_tx_data;
      if (w_out_push) r_out_mem[r_out_wp] <= cpu_out_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_in_wp     <= '0;
         r_in_rp     <= '0;
         r_out_wp    <= '0;
         r_out_rp    <= '0;
         r_in_cnt    <= '0;
         r_out_cnt   <= '0;
         r_in_sig_d  <= 1'b0;
         r_out_sig_d <= 1'b0;
         r_arm       <= 1'b0;
         r_unf       <= 1'b0;
         r_ovf       <= 1'b0;
      end else begin
         r_arm       <= 1'b1;
         r_in_sig_d  <= cpu_in_signal;
         r_out_sig_d <= cpu_out_signal;
         if (w_in_push)  r_in_wp  <= r_in_wp + 1'b1;
         if (w_in_pop)   r_in_rp  <= r_in_rp + 1'b1;
         if (w_out_push) r_out_wp <= r_out_wp + 1'b1;
         if (w_out_pop)  r_out_rp <= r_out_rp + 1'b1;
         r_in_cnt  <= r_in_cnt + CW'(w_in_push) - CW'(w_in_pop);
         r_out_cnt <= r_out_cnt + CW'(w_out_push) - CW'(w_out_pop);
         if (w_unf_set)        r_unf <= 1'b1;
         else if (clear_flags) r_unf <= 1'b0;
         if (w_ovf_set)        r_ovf <= 1'b1;
         else if (clear_flags) r_ovf <= 1'b0;
      end
   end

`ifdef IO_PORT_BRIDGE_STATS_EN
   logic [31:0] r_in_words, r_out_words;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_in_words  <= '0;
         r_out_words <= '0;
      end else begin
         if (w_in_pop)   r_in_words  <= r_in_words + 32'd1;
         if (w_out_push) r_out_words <= r_out_words + 32'd1;
      end
   end

   assign in_words  = r_in_words;
   assign out_words = r_out_words;
`endif

endmodule
